wb_actuator_slave: RTL and testbench

- Wishbone classic responder at the actuator end of the control loop.
- Accepts a command target over the bus or directly from the PID output (o_un / valid).
- Drives a rate-limited, range-clamped actuator position that bus masters (the Wishbone master BFM, loop sequencers) can read back.
- Sits between the PID block and the plant model.

---
 rtl/wb_actuator_slave_pkg.sv | 31 +++
 rtl/actuator_rate_limiter.sv | 77 +++++++
 rtl/wb_actuator_slave.sv | 152 +++++++++++++++
 tb/tb_wb_actuator_slave.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_actuator_slave_pkg.sv
// Shared register map, CTRL/STATUS bit positions and widths for the
// Wishbone actuator slave and its rate limiter.
package wb_actuator_slave_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned IDX_W  = 14;

    localparam logic [IDX_W-1:0] ADR_CMD      = 14'd0;
    localparam logic [IDX_W-1:0] ADR_RATE     = 14'd1;
    localparam logic [IDX_W-1:0] ADR_PERIOD   = 14'd2;
    localparam logic [IDX_W-1:0] ADR_CTRL     = 14'd3;
    localparam logic [IDX_W-1:0] ADR_POS      = 14'd4;
    localparam logic [IDX_W-1:0] ADR_STATUS   = 14'd5;
    localparam logic [IDX_W-1:0] ADR_LIMIT_HI = 14'd6;
    localparam logic [IDX_W-1:0] ADR_LIMIT_LO = 14'd7;

    localparam int unsigned CTRL_EN  = 0;
    localparam int unsigned CTRL_SRC = 1;

    localparam int unsigned STAT_MOVING   = 0;
    localparam int unsigned STAT_CLAMP_HI = 1;
    localparam int unsigned STAT_CLAMP_LO = 2;

    typedef struct packed {
        logic clamp_lo;
        logic clamp_hi;
        logic moving;
    } status_t;

endpackage

// File: rtl/actuator_rate_limiter.sv
// Tick divider, target clamp and rate-limited position stepper that sits
// behind the Wishbone register file of wb_actuator_slave.
module actuator_rate_limiter
    import wb_actuator_slave_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_en,
    input  logic signed [DATA_W-1:0] i_cmd,
    input  logic        [HALF_W-1:0] i_rate,
    input  logic        [HALF_W-1:0] i_period,
    input  logic signed [DATA_W-1:0] i_limit_hi,
    input  logic signed [DATA_W-1:0] i_limit_lo,
    output logic signed [DATA_W-1:0] o_pos,
    output logic                     o_tick,
    output status_t                  o_status_c
);

    logic        [HALF_W-1:0] r_cnt;
    logic signed [DATA_W-1:0] r_pos;
    logic                     r_tick;

    logic signed [DATA_W-1:0] w_hi_clip;
    logic signed [DATA_W-1:0] w_target;
    logic                     w_clamp_hi;
    logic                     w_clamp_lo;
    logic signed [DATA_W:0]   w_diff;
    logic        [DATA_W:0]   w_mag;
    logic        [DATA_W-1:0] w_rate_ext;
    logic        [DATA_W-1:0] w_pos_nxt;

    // Upper limit first, lower limit last so LIMIT_LO wins when the limits cross.
    always_comb begin
        w_clamp_hi = i_cmd > i_limit_hi;
        w_hi_clip  = w_clamp_hi ? i_limit_hi : i_cmd;
        w_clamp_lo = w_hi_clip < i_limit_lo;
        w_target   = w_clamp_lo ? i_limit_lo : w_hi_clip;
    end

    // 33-bit difference keeps full-range moves free of overflow.
    always_comb begin
        w_diff     = {w_target[DATA_W-1], w_target} - {r_pos[DATA_W-1], r_pos};
        w_mag      = w_diff[DATA_W] ? $unsigned(-w_diff) : $unsigned(w_diff);
        w_rate_ext = DATA_W'(i_rate);
        if (w_mag <= (DATA_W+1)'(i_rate)) begin
            w_pos_nxt = w_target;
        end else if (w_diff[DATA_W]) begin
            w_pos_nxt = r_pos - w_rate_ext;
        end else begin
            w_pos_nxt = r_pos + w_rate_ext;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_pos  <= '0;
            r_tick <= 1'b0;
        end else if (!i_en) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == i_period) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
            r_pos  <= w_pos_nxt;
        end else begin
            // A PERIOD lowered below the count lets it run on to wrap at 16'hFFFF.
            r_cnt  <= r_cnt + 16'd1;
            r_tick <= 1'b0;
        end
    end

    assign o_pos      = r_pos;
    assign o_tick     = r_tick;
    assign o_status_c = {w_clamp_lo, w_clamp_hi, (r_pos != w_target)};

endmodule

// File: rtl/wb_actuator_slave.sv
// Wishbone classic register front-end for the rate-limited actuator.
// Define WB_ERR_EN to answer unmapped or read-only-write accesses with ERR.
module wb_actuator_slave
    import wb_actuator_slave_pkg::*;
#(
    parameter logic [HALF_W-1:0] RST_RATE     = 16'd1,
    parameter logic [HALF_W-1:0] RST_PERIOD   = 16'd0,
    parameter logic [DATA_W-1:0] RST_LIMIT_HI = 32'h7FFF_FFFF,
    parameter logic [DATA_W-1:0] RST_LIMIT_LO = 32'h8000_0000
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cyc,
    input  logic              i_stb,
    input  logic              i_we,
    input  logic [15:0]       i_adr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_ack,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_err,
    input  logic [DATA_W-1:0] i_un,
    input  logic              i_valid,
    output logic [DATA_W-1:0] o_pos,
    output logic              o_tick
);

    logic [DATA_W-1:0] r_cmd;
    logic [HALF_W-1:0] r_rate;
    logic [HALF_W-1:0] r_period;
    logic              r_en;
    logic              r_src;
    logic [DATA_W-1:0] r_limit_hi;
    logic [DATA_W-1:0] r_limit_lo;
    logic              r_ack;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;

    logic [IDX_W-1:0]  w_idx;
    logic              w_req;
    logic              w_bad;
    logic              w_wr;
    logic              w_rd;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] w_pos;
    status_t           w_status;
    logic              w_unused;

    assign w_idx    = i_adr[15:2];
    assign w_unused = &{1'b0, i_adr[1:0]};

    // A pending ack/err blocks re-issue, so a held STB is answered every other cycle.
    assign w_req = i_cyc & i_stb & ~r_ack & ~r_err;

`ifdef WB_ERR_EN
    assign w_bad = (w_idx > ADR_LIMIT_LO) |
                   (i_we & ((w_idx == ADR_POS) | (w_idx == ADR_STATUS)));
`else
    assign w_bad = 1'b0;
`endif

    assign w_wr = w_req & i_we & ~w_bad;
    assign w_rd = w_req & ~i_we & ~w_bad;

    always_comb begin
        w_rdata = '0;
        case (w_idx)
            ADR_CMD:      w_rdata = r_cmd;
            ADR_RATE:     w_rdata = DATA_W'(r_rate);
            ADR_PERIOD:   w_rdata = DATA_W'(r_period);
            ADR_CTRL: begin
                w_rdata[CTRL_EN]  = r_en;
                w_rdata[CTRL_SRC] = r_src;
            end
            ADR_POS:      w_rdata = w_pos;
            ADR_STATUS: begin
                w_rdata[STAT_MOVING]   = w_status.moving;
                w_rdata[STAT_CLAMP_HI] = w_status.clamp_hi;
                w_rdata[STAT_CLAMP_LO] = w_status.clamp_lo;
            end
            ADR_LIMIT_HI: w_rdata = r_limit_hi;
            ADR_LIMIT_LO: w_rdata = r_limit_lo;
            default:      w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack <= w_req & ~w_bad;
            r_err <= w_req & w_bad;
            if (w_rd) begin
                r_rdata <= w_rdata;
            end
        end
    end

    // Register file; a bus write to CMD overrides a same-cycle PID sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cmd      <= '0;
            r_rate     <= RST_RATE;
            r_period   <= RST_PERIOD;
            r_en       <= 1'b0;
            r_src      <= 1'b0;
            r_limit_hi <= RST_LIMIT_HI;
            r_limit_lo <= RST_LIMIT_LO;
        end else begin
            if (w_wr) begin
                case (w_idx)
                    ADR_RATE:     r_rate     <= i_wdata[HALF_W-1:0];
                    ADR_PERIOD:   r_period   <= i_wdata[HALF_W-1:0];
                    ADR_CTRL: begin
                        r_en  <= i_wdata[CTRL_EN];
                        r_src <= i_wdata[CTRL_SRC];
                    end
                    ADR_LIMIT_HI: r_limit_hi <= i_wdata;
                    ADR_LIMIT_LO: r_limit_lo <= i_wdata;
                    default: ;
                endcase
            end
            if (w_wr && (w_idx == ADR_CMD)) begin
                r_cmd <= i_wdata;
            end else if (r_src && i_valid) begin
                r_cmd <= i_un;
            end
        end
    end

    actuator_rate_limiter u_limiter (
        .clk        (clk),
        .rst        (rst),
        .i_en       (r_en),
        .i_cmd      (r_cmd),
        .i_rate     (r_rate),
        .i_period   (r_period),
        .i_limit_hi (r_limit_hi),
        .i_limit_lo (r_limit_lo),
        .o_pos      (w_pos),
        .o_tick     (o_tick),
        .o_status_c (w_status)
    );

    assign o_ack   = r_ack;
    assign o_err   = r_err;
    assign o_rdata = r_rdata;
    assign o_pos   = w_pos;

endmodule

// File: tb/tb_wb_actuator_slave.sv
// Scoreboard bench for wb_actuator_slave: register map, slew, clamp,
// command source, handshake and tick-divider wrap.
module tb_wb_actuator_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_cyc = 1'b0;
    logic        i_stb = 1'b0;
    logic        i_we = 1'b0;
    logic [15:0] i_adr = '0;
    logic [31:0] i_wdata = '0;
    logic        o_ack;
    logic [31:0] o_rdata;
    logic        o_err;
    logic [31:0] i_un = '0;
    logic        i_valid = 1'b0;
    logic [31:0] o_pos;
    logic        o_tick;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    int          cyc_q[$];

    always #5 clk = ~clk;

    wb_actuator_slave dut (
        .clk     (clk),
        .rst     (rst),
        .i_cyc   (i_cyc),
        .i_stb   (i_stb),
        .i_we    (i_we),
        .i_adr   (i_adr),
        .i_wdata (i_wdata),
        .o_ack   (o_ack),
        .o_rdata (o_rdata),
        .o_err   (o_err),
        .i_un    (i_un),
        .i_valid (i_valid),
        .o_pos   (o_pos),
        .o_tick  (o_tick)
    );

    task automatic wb_xfer(input logic we, input int idx, input logic [31:0] wd,
                           output logic [31:0] rd, output logic a, output logic e,
                           output int lat);
        i_cyc = 1'b1; i_stb = 1'b1; i_we = we; i_adr = 16'(idx * 4); i_wdata = wd;
        a = 1'b0; e = 1'b0; lat = 0;
        while (!a && !e && lat < 8) begin
            @(posedge clk); #1;
            lat++;
            a = o_ack;
            e = o_err;
        end
        rd = o_rdata;
        i_cyc = 1'b0; i_stb = 1'b0; i_we = 1'b0;
        if (!a && !e) begin
            errors++; checks++;
            $display("FAIL wb_timeout idx=%0d: no ack/err after %0d cycles, required one", idx, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic wb_write(input int idx, input logic [31:0] wd);
        logic [31:0] rd; logic a, e; int lat;
        wb_xfer(1'b1, idx, wd, rd, a, e, lat);
    endtask

    task automatic wb_read(input int idx, output logic [31:0] rd, output logic a,
                           output logic e, output int lat);
        wb_xfer(1'b0, idx, 32'h0, rd, a, e, lat);
    endtask

    task automatic pulse_reset();
        rst = 1'b0; @(posedge clk); #1; rst = 1'b1; @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [31:0] tbl [8];
        logic [31:0] rd, exp_v; logic a, e; int lat;
        tbl = '{32'h0, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h7FFF_FFFF, 32'h8000_0000};
        rst = 1'b0; repeat (2) @(posedge clk); #1;
        checks++;
        if ({o_ack, o_err, o_tick} !== 3'b000)
            begin errors++; $display("FAIL reset_flags got %b required 000", {o_ack, o_err, o_tick}); end
        checks++;
        if (o_rdata !== 32'h0 || o_pos !== 32'h0)
            begin errors++; $display("FAIL reset_data rdata=%h pos=%h required 0/0", o_rdata, o_pos); end
        rst = 1'b1; @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(tbl[i]);
            wb_read(i, rd, a, e, lat);
            exp_v = exp_q.pop_front();
            checks++;
            if (rd !== exp_v || a !== 1'b1)
                begin errors++; $display("FAIL reset_reg%0d got %h ack=%b required %h ack=1", i, rd, a, exp_v); end
            checks++;
            if (lat != 1)
                begin errors++; $display("FAIL reset_lat%0d got %0d required 1", i, lat); end
        end
        wb_read(8, rd, a, e, lat);
`ifdef WB_ERR_EN
        exp_q.push_back(32'h8000_0000);
        exp_v = exp_q.pop_front();
        checks++;
        if (e !== 1'b1 || a !== 1'b0 || rd !== exp_v)
            begin errors++; $display("FAIL reset_reg8 got err=%b ack=%b rd=%h required 1/0/%h", e, a, rd, exp_v); end
`else
        exp_q.push_back(32'h0);
        exp_v = exp_q.pop_front();
        checks++;
        if (a !== 1'b1 || rd !== exp_v)
            begin errors++; $display("FAIL reset_reg8 got ack=%b rd=%h required 1/%h", a, rd, exp_v); end
`endif
    endtask

    task automatic test_slew();
        logic [31:0] rd, exp_v; logic a, e; int lat;
        wb_write(1, 32'd4);
        wb_write(2, 32'd0);
        wb_write(0, 32'd10);
        wb_write(3, 32'd1);
        exp_q.push_back(32'd4); exp_q.push_back(32'd8); exp_q.push_back(32'd10);
        for (int k = 0; k < 3; k++) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (o_pos !== exp_v || o_tick !== 1'b1)
                begin errors++; $display("FAIL slew_step%0d got pos=%h tick=%b required %h/1", k, o_pos, o_tick, exp_v); end
            @(posedge clk); #1;
        end
        exp_q.push_back(32'h0);
        wb_read(5, rd, a, e, lat);
        exp_v = exp_q.pop_front();
        checks++;
        if (rd !== exp_v)
            begin errors++; $display("FAIL slew_status got %h required %h", rd, exp_v); end
        exp_q.push_back(32'd10);
        wb_read(4, rd, a, e, lat);
        exp_v = exp_q.pop_front();
        checks++;
        if (rd !== exp_v)
            begin errors++; $display("FAIL slew_pos_read got %h required %h", rd, exp_v); end
    endtask

    task automatic test_period();
        logic [31:0] rd, exp_v; logic a, e; int lat, n, exp_n;
        pulse_reset();
        wb_write(2, 32'd3);
        wb_write(1, 32'd100);
        wb_write(0, 32'hFFFF_FF06);
        wb_write(3, 32'd1);
        exp_q.push_back(32'hFFFF_FF9C); cyc_q.push_back(3);
        exp_q.push_back(32'hFFFF_FF38); cyc_q.push_back(7);
        exp_q.push_back(32'hFFFF_FF06); cyc_q.push_back(11);
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            @(posedge clk); #1; n++;
            if (o_tick) begin
                exp_v = exp_q.pop_front();
                exp_n = cyc_q.pop_front();
                checks++;
                if (o_pos !== exp_v || n != exp_n)
                    begin errors++; $display("FAIL period_tick got pos=%h at %0d required %h at %0d", o_pos, n, exp_v, exp_n); end
            end
        end
        checks++;
        if (exp_q.size() != 0)
            begin errors++; $display("FAIL period_ticks got %0d missing required 0", exp_q.size()); exp_q.delete(); cyc_q.delete(); end
        exp_q.push_back(32'h0);
        wb_read(5, rd, a, e, lat);
        exp_v = exp_q.pop_front();
        checks++;
        if (rd !== exp_v)
            begin errors++; $display("FAIL period_status got %h required %h", rd, exp_v); end
    endtask

    task automatic test_clamp();
        logic [31:0] rd, exp_v; logic a, e; int lat;
        logic [31:0] exp_pos [3];
        logic [31:0] exp_st [3];
        exp_pos = '{32'd50, 32'd60, 32'd60};
        exp_st  = '{32'h2, 32'h6, 32'h1};
        pulse_reset();
        for (int s = 0; s < 3; s++) begin
            if (s == 0) begin
                wb_write(6, 32'd50); wb_write(1, 32'd1000);
                wb_write(0, 32'd1000); wb_write(3, 32'd1);
            end else if (s == 1) begin
                wb_write(7, 32'd60);
            end else begin
                wb_write(1, 32'd0); wb_write(7, 32'h8000_0000); wb_write(0, 32'd0);
            end
            repeat (4) @(posedge clk); #1;
            exp_q.push_back(exp_pos[s]);
            exp_q.push_back(exp_st[s]);
            wb_read(4, rd, a, e, lat);
            exp_v = exp_q.pop_front();
            checks++;
            if (rd !== exp_v)
                begin errors++; $display("FAIL clamp_pos%0d got %h required %h", s, rd, exp_v); end
            wb_read(5, rd, a, e, lat);
            exp_v = exp_q.pop_front();
            checks++;
            if (rd !== exp_v)
                begin errors++; $display("FAIL clamp_status%0d got %h required %h", s, rd, exp_v); end
        end
    endtask

    task automatic test_src();
        logic [31:0] rd, exp_v; logic a, e; int lat;
        pulse_reset();
        wb_write(3, 32'd3);
        i_un = 32'h20; i_valid = 1'b1;
        i_cyc = 1'b1; i_stb = 1'b1; i_we = 1'b1; i_adr = 16'h0; i_wdata = 32'h30;
        @(posedge clk); #1;
        i_valid = 1'b0;
        checks++;
        if (o_ack !== 1'b1)
            begin errors++; $display("FAIL src_collide_ack got %b required 1", o_ack); end
        i_cyc = 1'b0; i_stb = 1'b0; i_we = 1'b0;
        @(posedge clk); #1;
        exp_q.push_back(32'h30);
        wb_read(0, rd, a, e, lat);
        exp_v = exp_q.pop_front();
        checks++;
        if (rd !== exp_v)
            begin errors++; $display("FAIL src_bus_wins got %h required %h", rd, exp_v); end
        i_valid = 1'b1; @(posedge clk); #1; i_valid = 1'b0;
        exp_q.push_back(32'h20);
        wb_read(0, rd, a, e, lat);
        exp_v = exp_q.pop_front();
        checks++;
        if (rd !== exp_v)
            begin errors++; $display("FAIL src_pid_load got %h required %h", rd, exp_v); end
        wb_write(3, 32'd1);
        i_un = 32'h99; i_valid = 1'b1; @(posedge clk); #1; i_valid = 1'b0;
        exp_q.push_back(32'h20);
        wb_read(0, rd, a, e, lat);
        exp_v = exp_q.pop_front();
        checks++;
        if (rd !== exp_v)
            begin errors++; $display("FAIL src_off_ignored got %h required %h", rd, exp_v); end
    endtask

    task automatic test_unmapped();
        logic [31:0] rd, exp_v; logic a, e; int lat;
        pulse_reset();
        wb_write(0, 32'h1234);
        exp_q.push_back(32'h1234);
        wb_read(0, rd, a, e, lat);
        exp_v = exp_q.pop_front();
        checks++;
        if (rd !== exp_v)
            begin errors++; $display("FAIL unmap_cmd got %h required %h", rd, exp_v); end
        wb_xfer(1'b1, 4, 32'hDEAD, rd, a, e, lat);
`ifdef WB_ERR_EN
        checks++;
        if (e !== 1'b1 || a !== 1'b0)
            begin errors++; $display("FAIL unmap_wr_pos got err=%b ack=%b required 1/0", e, a); end
        exp_q.push_back(32'h1234);
`else
        checks++;
        if (a !== 1'b1 || e !== 1'b0)
            begin errors++; $display("FAIL unmap_wr_pos got ack=%b err=%b required 1/0", a, e); end
        exp_q.push_back(32'h0);
`endif
        wb_read(9, rd, a, e, lat);
        exp_v = exp_q.pop_front();
        checks++;
`ifdef WB_ERR_EN
        if (e !== 1'b1 || a !== 1'b0 || rd !== exp_v)
            begin errors++; $display("FAIL unmap_rd9 got err=%b ack=%b rd=%h required 1/0/%h", e, a, rd, exp_v); end
`else
        if (a !== 1'b1 || e !== 1'b0 || rd !== exp_v)
            begin errors++; $display("FAIL unmap_rd9 got ack=%b err=%b rd=%h required 1/0/%h", a, e, rd, exp_v); end
`endif
        exp_q.push_back(32'h0);
        wb_read(4, rd, a, e, lat);
        exp_v = exp_q.pop_front();
        checks++;
        if (rd !== exp_v || o_pos !== exp_v)
            begin errors++; $display("FAIL unmap_pos_kept got rd=%h pos=%h required %h", rd, o_pos, exp_v); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_v;
        i_cyc = 1'b1; i_stb = 1'b1; i_we = 1'b0; i_adr = 16'h4;
        for (int k = 0; k < 6; k++) exp_q.push_back((k % 2 == 0) ? 32'd1 : 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            exp_v = exp_q.pop_front();
            checks++;
            if (o_ack !== exp_v[0])
                begin errors++; $display("FAIL b2b_ack%0d got %b required %b", k, o_ack, exp_v[0]); end
        end
        checks++;
        if (o_rdata !== 32'd1)
            begin errors++; $display("FAIL b2b_rdata got %h required 00000001", o_rdata); end
        i_cyc = 1'b0; i_stb = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_cyc_drop();
        i_cyc = 1'b1; i_stb = 1'b1; i_we = 1'b0; i_adr = 16'h0;
        @(posedge clk); #1;
        checks++;
        if (o_ack !== 1'b1)
            begin errors++; $display("FAIL drop_first got %b required 1", o_ack); end
        i_cyc = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            checks++;
            if (o_ack !== 1'b0)
                begin errors++; $display("FAIL drop_after%0d got %b required 0", k, o_ack); end
        end
        i_stb = 1'b0;
        @(posedge clk); #1;
        i_cyc = 1'b1; i_stb = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (o_ack !== 1'b1)
            begin errors++; $display("FAIL mid_reset_pre got %b required 1", o_ack); end
        rst = 1'b0; #1;
        checks++;
        if (o_ack !== 1'b0)
            begin errors++; $display("FAIL mid_reset_ack got %b required 0", o_ack); end
        i_cyc = 1'b0; i_stb = 1'b0;
        @(posedge clk); #1; rst = 1'b1; @(posedge clk); #1;
    endtask

    task automatic test_period_wrap();
        int n;
        pulse_reset();
        wb_write(1, 32'd1);
        wb_write(0, 32'd1000);
        wb_write(2, 32'd10);
        wb_write(3, 32'd1);
        wb_write(2, 32'd1);
        n = 0;
        while (n < 70000) begin
            @(posedge clk); #1; n++;
            if (o_tick) break;
        end
        checks++;
        if (n != 65535)
            begin errors++; $display("FAIL wrap_tick_cycle got %0d required 65535", n); end
        checks++;
        if (o_pos !== 32'd1)
            begin errors++; $display("FAIL wrap_pos got %h required 00000001", o_pos); end
    endtask

    initial begin
        test_reset();
        test_slew();
        test_period();
        test_clamp();
        test_src();
        test_unmapped();
        test_back_to_back();
        test_cyc_drop();
        test_period_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
